// File: rtl/bus_pkg.sv
// Shared bus definitions: master IDs, request bundle and the address map used by bus and data_arbiter.
package bus_pkg;

  localparam logic MID_CORE = 1'b0;
  localparam logic MID_DMA  = 1'b1;

  // Region field of the byte address selects the slave on the bus.
  localparam int REGION_LSB = 13;
  localparam int REGION_MSB = 16;
  localparam logic [3:0] REGION_RAM0  = 4'd0;
  localparam logic [3:0] REGION_RAM1  = 4'd1;
  localparam logic [3:0] REGION_RAM2  = 4'd2;
  localparam logic [3:0] REGION_RAM3  = 4'd3;
  localparam logic [3:0] REGION_ROM   = 4'd4;
  localparam logic [3:0] REGION_UART  = 4'd5;
  localparam logic [3:0] REGION_TIMER = 4'd6;
  localparam logic [3:0] REGION_GPIO  = 4'd7;
  localparam logic [3:0] REGION_DBG   = 4'd8;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  function automatic logic [3:0] region_of(input logic [31:0] addr);
    return addr[REGION_MSB:REGION_LSB];
  endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of 1-bit master IDs for outstanding bus transactions.
module id_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr, wr_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Full push+pop writes the slot being read; dout already sampled the old value.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_arbiter.sv
// Two-master arbiter sharing one bus data port; routes in-order responses back by ID.
module data_arbiter
  import bus_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(DEPTH + 1);

  mreq_t         m0, m1, sel_req;
  logic          sel, last_q, push, pop, head, full, empty, slot_ok;
  logic [CW-1:0] count;

  assign m0 = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1 = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

  always_comb begin
    sel = MID_CORE;
    if (m0_req_i && m1_req_i) sel = FIXED_PRIO ? MID_CORE : ~last_q;
    else if (m1_req_i)        sel = MID_DMA;
  end

  assign sel_req     = (sel == MID_DMA) ? m1 : m0;
  assign bus_we_o    = sel_req.we;
  assign bus_be_o    = sel_req.be;
  assign bus_addr_o  = sel_req.addr;
  assign bus_wdata_o = sel_req.wdata;

  // A response in the same cycle frees a slot, so a full FIFO still sustains 1/cycle.
  assign slot_ok   = ~full | (bus_rvalid_i & (count != '0));
  assign bus_req_o = rst_i & (m0_req_i | m1_req_i) & slot_ok;
  assign push      = bus_req_o & bus_gnt_i;
  assign pop       = rst_i & bus_rvalid_i & ~empty;

  assign m0_gnt_o    = push & (sel == MID_CORE);
  assign m1_gnt_o    = push & (sel == MID_DMA);
  assign m0_rvalid_o = pop & (head == MID_CORE);
  assign m1_rvalid_o = pop & (head == MID_DMA);
  assign m0_rdata_o  = bus_rdata_i;
  assign m1_rdata_o  = bus_rdata_i;

  id_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // last_q resets to DMA so the first tie after reset goes to the core.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= MID_DMA;
      err_o  <= 1'b0;
    end else begin
      if (push)                  last_q <= sel;
      if (bus_rvalid_i && empty) err_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters driven by the same stimulus.
module tb_data_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        bus_gnt = 0, bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_req, bus_we, err;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_bus_req, f_bus_we, f_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_bus_addr, f_bus_wdata;
  logic [3:0]  f_bus_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_arbiter #(.DEPTH(2), .FIXED_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .err_o(err)
  );

  data_arbiter #(.DEPTH(2), .FIXED_PRIO(1'b1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata),
    .bus_req_o(f_bus_req), .bus_we_o(f_bus_we), .bus_be_o(f_bus_be), .bus_addr_o(f_bus_addr),
    .bus_wdata_o(f_bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .err_o(f_err)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_be = 0; m1_be = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    m0_req = 1; m1_req = 1; bus_gnt = 1; bus_rvalid = 1;
    next_cycle();
    settle();
    n_checks++;
    if ({bus_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req/g0/g1/rv0/rv1/err=%b required 000000",
               {bus_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err});
    end
    idle_inputs();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_single();
    bus_gnt = 1; m0_req = 1; m0_addr = 32'h0000_0010; m0_be = 4'hF;
    settle();
    n_checks++;
    if ({m0_gnt, m1_gnt, bus_req} !== 3'b101 || bus_addr !== 32'h10 || bus_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt: got g0/g1/req=%b addr=%h we=%b required 101 addr=00000010 we=0",
               {m0_gnt, m1_gnt, bus_req}, bus_addr, bus_we);
    end
    next_cycle();
    m0_req = 0; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    n_checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_resp: got rv0=%b rv1=%b data=%h required rv0=1 rv1=0 data=deadbeef",
               m0_rvalid, m1_rvalid, m0_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Both masters request for 6 cycles; each cycle also returns the previous beat.
  task automatic test_round_robin();
    logic exp_id;
    do_reset();
    bus_gnt = 1; m0_req = 1; m1_req = 1;
    m0_addr = 32'h100; m1_addr = 32'h200;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) begin m0_req = 0; m1_req = 0; end
      bus_rvalid = (k > 0);
      bus_rdata  = 32'hA000_0000 + k;
      settle();
      if (k < 6) begin
        exp_id = k[0];
        n_checks++;
        if (m0_gnt !== ~exp_id || m1_gnt !== exp_id || bus_addr !== (exp_id ? 32'h200 : 32'h100)) begin
          n_fail++;
          $display("FAIL rr_gnt[%0d]: got g0=%b g1=%b addr=%h required g0=%b g1=%b",
                   k, m0_gnt, m1_gnt, bus_addr, ~exp_id, exp_id);
        end
        n_checks++;
        if (f_m0_gnt !== 1'b1 || f_m1_gnt !== 1'b0) begin
          n_fail++;
          $display("FAIL fixed_gnt[%0d]: got g0=%b g1=%b required g0=1 g1=0", k, f_m0_gnt, f_m1_gnt);
        end
      end
      if (k > 0) begin
        exp_id = ~k[0];
        n_checks++;
        if (m0_rvalid !== ~exp_id || m1_rvalid !== exp_id ||
            m0_rdata !== 32'hA000_0000 + k || m1_rdata !== 32'hA000_0000 + k) begin
          n_fail++;
          $display("FAIL rr_resp[%0d]: got rv0=%b rv1=%b data=%h required rv0=%b rv1=%b data=%h",
                   k, m0_rvalid, m1_rvalid, m0_rdata, ~exp_id, exp_id, 32'hA000_0000 + k);
        end
        n_checks++;
        if (f_m0_rvalid !== 1'b1 || f_m1_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL fixed_resp[%0d]: got rv0=%b rv1=%b required rv0=1 rv1=0",
                   k, f_m0_rvalid, f_m1_rvalid);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    bus_gnt = 1; m0_req = 1; m0_addr = 32'h40;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if (m0_gnt !== 1'b1 || bus_req !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_fill[%0d]: got g0=%b req=%b required 1 1", k, m0_gnt, bus_req);
      end
      next_cycle();
    end
    settle();
    n_checks++;
    if (m0_gnt !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got g0=%b req=%b required 0 0", m0_gnt, bus_req);
    end
    next_cycle();
    bus_rvalid = 1; bus_rdata = 32'h0000_0B0B;
    settle();
    n_checks++;
    if (m0_gnt !== 1'b1 || bus_req !== 1'b1 || m0_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_popthru: got g0=%b req=%b rv0=%b required 1 1 1", m0_gnt, bus_req, m0_rvalid);
    end
    next_cycle();
    bus_rvalid = 0;
    settle();
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_still_full: got req=%b required 0", bus_req);
    end
    next_cycle();
    m0_req = 0; bus_rvalid = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++;
      if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got rv0=%b rv1=%b required 1 0", k, m0_rvalid, m1_rvalid);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_gnt_stall();
    m1_req = 1; m1_we = 1; m1_be = 4'hF; m1_addr = 32'h0001_0000; m1_wdata = 32'h1234_5678;
    bus_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if (m1_gnt !== 1'b0 || bus_req !== 1'b1 || bus_we !== 1'b1 ||
          bus_addr !== 32'h0001_0000 || bus_wdata !== 32'h1234_5678 || bus_be !== 4'hF) begin
        n_fail++;
        $display("FAIL stall[%0d]: got g1=%b req=%b we=%b addr=%h wdata=%h be=%h required 0 1 1 00010000 12345678 f",
                 k, m1_gnt, bus_req, bus_we, bus_addr, bus_wdata, bus_be);
      end
      next_cycle();
    end
    bus_gnt = 1;
    settle();
    n_checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got g1=%b g0=%b required 1 0", m1_gnt, m0_gnt);
    end
    next_cycle();
    m1_req = 0; bus_rvalid = 1; bus_rdata = 32'h0000_00AC;
    settle();
    n_checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hAC) begin
      n_fail++;
      $display("FAIL stall_resp: got rv1=%b rv0=%b data=%h required 1 0 000000ac", m1_rvalid, m0_rvalid, m1_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  // FIFO is empty here: only one response was owed by the stalled write.
  task automatic test_spurious();
    settle();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_before: got err=%b required 0", err);
    end
    next_cycle();
    bus_rvalid = 1;
    settle();
    n_checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_route: got rv0=%b rv1=%b required 0 0", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    bus_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky[%0d]: got err=%b required 1", k, err);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    bus_gnt = 1; m0_req = 1;
    next_cycle();
    next_cycle();
    m0_req = 0;
    rst = 0;
    m0_req = 1; m1_req = 1; bus_rvalid = 1;
    settle();
    n_checks++;
    if ({bus_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req/g0/g1/rv0/rv1/err=%b required 000000",
               {bus_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err});
    end
    next_cycle();
    idle_inputs();
    rst = 1;
    bus_rvalid = 1;
    settle();
    n_checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_fifo_cleared: got rv0=%b rv1=%b required 0 0", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    bus_rvalid = 0; bus_gnt = 1; m0_req = 1; m1_req = 1;
    settle();
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_tie: got g0=%b g1=%b required 1 0", m0_gnt, m1_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    next_cycle();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_gnt_stall();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_arbiter.md
# data_arbiter

Two-master arbiter in front of the `bus` data port. It shares the single request/grant/rvalid data channel between the core LSU (master 0) and a second master such as DMA or debug (master 1). It selects one request per cycle using round-robin or fixed priority, forwards it to the bus, and tracks outstanding transactions in an ID FIFO. Each returning `bus_rvalid_i` is routed back to the master that issued the transaction.

## Interface
Parameters:
- `DEPTH`, 2: maximum outstanding transactions (ID FIFO depth); legal values 1–8.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = master 0 always wins.

Ports:
- `clk_i`  in  1  single clock; all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `m0_req_i`, `m1_req_i`  in  1  master request.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_gnt_o`, `m1_gnt_o`  out  1  request accepted this cycle.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response for this master.
- `m0_rdata_o`, `m1_rdata_o`  out  32  response data; both are driven from `bus_rdata_i`.
- `bus_req_o`, `bus_we_o`  out  1  to bus `data_req_i` / `data_we_i`.
- `bus_be_o`  out  4  to bus `data_be_i`.
- `bus_addr_o`, `bus_wdata_o`  out  32  to bus address / write data.
- `bus_gnt_i`  in  1  from bus `data_gnt_o`.
- `bus_rvalid_i`  in  1  from bus `data_rvalid_o`.
- `bus_rdata_i`  in  32  from bus `data_rdata_o`.
- `err_o`  out  1  sticky flag: a response arrived with no outstanding transaction.

## Operation
- **Transactions:** every accepted transaction, read or write, produces exactly one `bus_rvalid_i`. Responses return in order.
- **Selection (combinational):**
  - Only one master requesting: that master is selected.
  - Both requesting, `FIXED_PRIO=1`: master 0 is selected.
  - Both requesting, `FIXED_PRIO=0`: the master opposite to `last_q` is selected.
- **Forwarding:** the selected master's we/be/addr/wdata are muxed onto `bus_*_o`.
- **Slot available:** `slot_ok = (count < DEPTH) | (bus_rvalid_i & count != 0)`. This allows pop-through when the FIFO is full.
- **Bus request:** `bus_req_o = (m0_req_i | m1_req_i) & slot_ok`.
- **Grant:** `mX_gnt_o = bus_req_o & bus_gnt_i & selected==X`. The non-selected master always sees gnt=0.
- **Accepted transfer** (`bus_req_o & bus_gnt_i`):
  - Push the selected ID to the FIFO tail.
  - Set `last_q` to the selected ID.
- **Response** (`bus_rvalid_i`, FIFO not empty):
  - Pop the FIFO head.
  - Drive `mX_rvalid_o = 1` for X = head ID.
- **Response with empty FIFO:** dropped; no master rvalid; `err_o` is set.
- **Simultaneous push and pop:** count is unchanged, the head advances, and the new ID is written at the tail.
- **Mid-transaction reset:** FIFO is cleared and in-flight responses are lost. Masters are reset together with the arbiter.

## Timing
- **Reset values:**
  - `count` = 0, FIFO pointers = 0, `last_q` = 1 (so master 0 wins the first tie), `err_o` = 0.
  - `bus_req_o`, `mX_gnt_o` and `mX_rvalid_o` are forced 0 while `rst_i` is low.
- **Grant latency:** 0 cycles. Request, grant and bus request occur in the same cycle; no arbitration bubble.
- **Response latency:** `mX_rvalid_o`/`mX_rdata_o` are combinational from `bus_rvalid_i`/`bus_rdata_i`, adding 0 cycles. With the `bus` 1-cycle rvalid, the master sees its response on the cycle after gnt.
- **Throughput:** one transaction per cycle. At `DEPTH=1` it is still 1/cycle because of pop-through.
- **Round-robin:** with both masters requesting continuously, grants alternate 0,1,0,1,… starting from master 0 after reset.
- **Request stability:** masters must hold req/we/be/addr/wdata stable until gnt. The arbiter does not check this.

## Structure
- **Package `bus_pkg`:**
  - Master ID constants `MID_CORE=0`, `MID_DMA=1`.
  - Bus address map constants (region field `addr[16:13]`, region codes 0–8) shared with `bus`.
- **Sub-module `id_fifo`:**
  - Synchronous FIFO of 1-bit IDs, parameter `DEPTH`.
  - Ports: push/pop/din/dout, full/empty, count.
  - Async active-low reset.
- **Top level:** the arbiter itself is a selection mux, `last_q`, `err_o` and glue logic.

## Test plan
- **Single master:** m0 read at `0x0000_0010`, gnt tied 1, bus responds next cycle with `0xDEADBEEF` → `m0_gnt_o=1` in the request cycle; `m0_rvalid_o=1` with `0xDEADBEEF` one cycle later; `m1_rvalid_o` stays 0.
- **Round-robin:** both masters request every cycle for 6 cycles → grants go 0,1,0,1,0,1. Responses route in the same order with distinct data per beat. With `FIXED_PRIO=1`, all 6 grants go to m0.
- **Backpressure:** `DEPTH=2`, responses withheld → two grants, then `bus_req_o=0` and gnt=0. An rvalid in the same cycle as a pending request pops and grants in that cycle, and count stays 2.
- **Gnt stall:** `bus_gnt_i=0` for 3 cycles with m1 requesting a write of `0x1234_5678` to `0x0001_0000` → no grant, no FIFO push. On `bus_gnt_i=1`, m1 is granted and one m1 rvalid follows.
- **Spurious response:** `bus_rvalid_i=1` with FIFO empty → no master rvalid, and `err_o=1` stays set until reset.
- **Reset mid-operation:** assert `rst_i` low with 2 outstanding → all outputs 0 and count 0. After release, a tie grants m0 first.
